// File: rtl/serial_add_requester.sv
// Initiator for the SerialAdder start/done interface: takes operand pairs, runs one add, returns the sum.
// Optional macro SERADD_TIMEOUT_EN adds a WAIT-state timeout that returns an error result.
module serial_add_requester #(
    parameter int W           = 8,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_err,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_start,
    output logic         add_rst,
    input  logic [W-1:0] add_c,
    input  logic         add_done
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is never withdrawn before the transfer and its payload stays constant while waiting.

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CLEAR,
        S_HOLD
    } state_t;

    localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [SCW-1:0] START_LOAD = SCW'(START_CYC - 1);

    state_t         state, state_nx;
    logic [SCW-1:0] start_cnt, start_cnt_nx;
    logic [W-1:0]   a_nx, b_nx, sum_nx;
    logic           in_ready_nx, out_valid_nx, add_start_nx, add_rst_nx;

`ifdef SERADD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] wait_cnt, wait_cnt_nx;
    logic          err_q, err_nx;

    assign out_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nx;
            err_q    <= err_nx;
        end
    end
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            start_cnt <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_start <= 1'b0;
            add_rst   <= 1'b1;
        end else begin
            state     <= state_nx;
            start_cnt <= start_cnt_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            out_sum   <= sum_nx;
            add_a     <= a_nx;
            add_b     <= b_nx;
            add_start <= add_start_nx;
            add_rst   <= add_rst_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        start_cnt_nx = start_cnt;
        a_nx         = add_a;
        b_nx         = add_b;
        sum_nx       = out_sum;
`ifdef SERADD_TIMEOUT_EN
        wait_cnt_nx  = wait_cnt;
        err_nx       = err_q;
`endif

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    a_nx         = in_a;
                    b_nx         = in_b;
                    start_cnt_nx = START_LOAD;
                    state_nx     = S_START;
                end
            end
            S_START: begin
                // add_done is deliberately not looked at here: it may still be high from the last op
                if (start_cnt == '0) begin
                    state_nx = S_WAIT;
`ifdef SERADD_TIMEOUT_EN
                    wait_cnt_nx = '0;
`endif
                end else begin
                    start_cnt_nx = start_cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (add_done) begin
                    sum_nx   = add_c;
                    state_nx = S_CLEAR;
`ifdef SERADD_TIMEOUT_EN
                    err_nx   = 1'b0;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    sum_nx   = '0;
                    err_nx   = 1'b1;
                    state_nx = S_CLEAR;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
`endif
                end
            end
            S_CLEAR: begin
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Every handshake/adder control output is a registered decode of the next state
        in_ready_nx  = (state_nx == S_IDLE);
        add_start_nx = (state_nx == S_START);
        add_rst_nx   = (state_nx == S_CLEAR);
        out_valid_nx = (state_nx == S_HOLD);
    end

endmodule
